// File: rtl/fifo_tx_drain_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_tx_drain_ctrl : drains a show-ahead TX FIFO into the UART transmitter,
// with flush, sent-byte counter and busy-handshake timeout. Macro: TX_GAP_EN.
// Revision: 1.0
// ============================================================================
module fifo_tx_drain_ctrl #(
   parameter int CNT_W        = 8,
   parameter int TO_W         = 4,
   parameter int BUSY_TIMEOUT = 8,
   parameter int GAP_CYCLES   = 2
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             enable,
   input  logic             flush,
   input  logic             fifo_empty,
   input  logic [7:0]       fifo_rdata,
   output logic             fifo_renable,
   input  logic             tx_busy,
   output logic             tx_start,
   output logic [7:0]       tx_data,
   output logic             active,
   output logic [CNT_W-1:0] sent_count,
   output logic             err_timeout,
   input  logic             err_clear
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FLUSH     = 3'd1;
   localparam logic [2:0] S_LOAD      = 3'd2;
   localparam logic [2:0] S_START     = 3'd3;
   localparam logic [2:0] S_WAIT_BUSY = 3'd4;
   localparam logic [2:0] S_WAIT_DONE = 3'd5;
`ifdef TX_GAP_EN
   localparam logic [2:0] S_GAP       = 3'd6;
   localparam int         GAP_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
`endif

   // Timeout fires on the last permitted WAIT_BUSY cycle without an acknowledge.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

   logic [2:0]      state;
   logic [2:0]      state_nxt;
   logic [TO_W-1:0] to_cnt;
   logic            load_byte;
   logic            clr_to;
   logic            inc_to;
   logic            timeout_hit;
   logic            byte_done;
`ifdef TX_GAP_EN
   logic [GAP_W-1:0] gap_cnt;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (flush && !fifo_empty)                      state_nxt = S_FLUSH;
            else if (enable && !fifo_empty && !tx_busy)    state_nxt = S_LOAD;
         end
         S_FLUSH: begin
            if (fifo_empty || !flush) state_nxt = S_IDLE;
         end
         S_LOAD:  state_nxt = S_START;
         S_START: state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (tx_busy)                  state_nxt = S_WAIT_DONE;
            else if (to_cnt == TO_LAST)   state_nxt = S_IDLE;
         end
         S_WAIT_DONE: begin
`ifdef TX_GAP_EN
            if (!tx_busy) state_nxt = S_GAP;
`else
            if (!tx_busy) state_nxt = S_IDLE;
`endif
         end
`ifdef TX_GAP_EN
         S_GAP: begin
            if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      fifo_renable = 1'b0;
      tx_start     = 1'b0;
      active       = (state != S_IDLE);
      load_byte    = 1'b0;
      clr_to       = 1'b0;
      inc_to       = 1'b0;
      timeout_hit  = 1'b0;
      byte_done    = 1'b0;
      case (state)
         S_FLUSH: fifo_renable = flush && !fifo_empty;
         S_LOAD: begin
            fifo_renable = 1'b1;
            load_byte    = 1'b1;
         end
         S_START: begin
            tx_start = 1'b1;
            clr_to   = 1'b1;
         end
         S_WAIT_BUSY: begin
            inc_to      = !tx_busy;
            timeout_hit = !tx_busy && (to_cnt == TO_LAST);
         end
         S_WAIT_DONE: byte_done = !tx_busy;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         to_cnt      <= '0;
         tx_data     <= 8'h00;
         sent_count  <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (clr_to)      to_cnt <= '0;
         else if (inc_to) to_cnt <= to_cnt + 1'b1;
         if (load_byte)   tx_data <= fifo_rdata;
         if (byte_done)   sent_count <= sent_count + 1'b1;
         // A fresh timeout outranks a simultaneous clear request.
         if (timeout_hit)    err_timeout <= 1'b1;
         else if (err_clear) err_timeout <= 1'b0;
      end
   end

`ifdef TX_GAP_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                  gap_cnt <= '0;
      else if (state != S_GAP)     gap_cnt <= '0;
      else                         gap_cnt <= gap_cnt + 1'b1;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_tx_drain_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fifo_tx_drain_ctrl : randomized bench with FIFO/transmitter models.
// Revision: 1.0
// ============================================================================
module tb_fifo_tx_drain_ctrl;

   localparam int CNT_W        = 8;
   localparam int TO_W         = 4;
   localparam int BUSY_TIMEOUT = 8;

   logic             clk = 1'b0;
   logic             n_rst;
   logic             enable;
   logic             flush;
   logic             fifo_empty;
   logic [7:0]       fifo_rdata;
   logic             fifo_renable;
   logic             tx_busy;
   logic             tx_start;
   logic [7:0]       tx_data;
   logic             active;
   logic [CNT_W-1:0] sent_count;
   logic             err_timeout;
   logic             err_clear;

   int n_checks = 0;
   int n_pass   = 0;

   // Environment models: show-ahead FIFO contents and a transmitter log.
   logic [7:0] fifo_q[$];
   logic [7:0] tx_log[$];
   int         start_t[$];
   int         cyc = 0;
   int         pop_total = 0;
   int         start_total = 0;
   int         underflow = 0;
   int         busy_left = 0;
   int         busy_len;
   bit         tx_mute;
   int         exp_sent = 0;
   logic       s_pop, s_start;
   logic [7:0] s_data;

   fifo_tx_drain_ctrl #(
      .CNT_W(CNT_W), .TO_W(TO_W), .BUSY_TIMEOUT(BUSY_TIMEOUT), .GAP_CYCLES(2)
   ) dut (
      .clk(clk), .n_rst(n_rst), .enable(enable), .flush(flush),
      .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_renable(fifo_renable),
      .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .active(active),
      .sent_count(sent_count), .err_timeout(err_timeout), .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   initial begin
      fifo_empty = 1'b1;
      fifo_rdata = 8'h00;
      tx_busy    = 1'b0;
      forever begin
         @(negedge clk);
         s_pop   = fifo_renable;
         s_start = tx_start;
         s_data  = tx_data;
         @(posedge clk);
         #1;
         cyc++;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
         end
         if (n_rst && s_start) begin
            start_total++;
            start_t.push_back(cyc);
            if (!tx_mute) begin
               tx_log.push_back(s_data);
               tx_busy   = 1'b1;
               busy_left = busy_len;
            end
         end
         if (n_rst && s_pop) begin
            pop_total++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            else underflow++;
         end
         fifo_empty = (fifo_q.size() == 0);
         fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
      end
   end

   task automatic drain(input int budget, input bit need_empty, output bit ok);
      int idle_run = 0;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((!need_empty || fifo_q.size() == 0) && !active && !tx_busy) idle_run++;
         else idle_run = 0;
         if (idle_run >= 3) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (active !== 1'b0) $display("FAIL reset_active: got %b exp 0", active); else n_pass++;
      n_checks++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b exp 0", tx_start); else n_pass++;
      n_checks++; if (fifo_renable !== 1'b0) $display("FAIL reset_renable: got %b exp 0", fifo_renable); else n_pass++;
      n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h exp 00", tx_data); else n_pass++;
      n_checks++; if (sent_count !== '0) $display("FAIL reset_sent_count: got %0d exp 0", sent_count); else n_pass++;
      n_checks++; if (err_timeout !== 1'b0) $display("FAIL reset_err: got %b exp 0", err_timeout); else n_pass++;
      n_rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_byte();
      int ren_at = -1, st_at = -1, ren_n = 0, st_n = 0;
      logic [7:0] st_data = 8'h00;
      busy_len = 10;
      fifo_q.push_back(8'hF0);
      enable = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (fifo_renable) begin ren_n++; if (ren_at < 0) ren_at = i; end
         if (tx_start) begin st_n++; if (st_at < 0) begin st_at = i; st_data = tx_data; end end
      end
      enable = 1'b0;
      exp_sent++;
      n_checks++; if (ren_at != 2) $display("FAIL single_renable_latency: got %0d exp 2", ren_at); else n_pass++;
      n_checks++; if (st_at != 3) $display("FAIL single_start_latency: got %0d exp 3", st_at); else n_pass++;
      n_checks++; if (ren_n != 1) $display("FAIL single_renable_cycles: got %0d exp 1", ren_n); else n_pass++;
      n_checks++; if (st_n != 1) $display("FAIL single_start_cycles: got %0d exp 1", st_n); else n_pass++;
      n_checks++; if (st_data !== 8'hF0) $display("FAIL single_tx_data: got %h exp f0", st_data); else n_pass++;
      n_checks++; if (sent_count !== CNT_W'(exp_sent)) $display("FAIL single_sent_count: got %0d exp %0d", sent_count, exp_sent); else n_pass++;
      n_checks++; if (active !== 1'b0) $display("FAIL single_active_after: got %b exp 0", active); else n_pass++;
      n_checks++; if (tx_data !== 8'hF0) $display("FAIL single_tx_data_hold: got %h exp f0", tx_data); else n_pass++;
   endtask

   task automatic test_burst();
      logic [7:0] pat [4] = '{8'hF0, 8'h0F, 8'hAA, 8'h55};
      int lb = tx_log.size();
      int sb = start_t.size();
      bit ok;
      busy_len = 6;
      for (int i = 0; i < 4; i++) fifo_q.push_back(pat[i]);
      enable = 1'b1;
      drain(300, 1'b1, ok);
      enable = 1'b0;
      exp_sent += 4;
      n_checks++; if (!ok) $display("FAIL burst_drain_timeout: got busy exp idle"); else n_pass++;
      n_checks++; if (tx_log.size() - lb != 4) $display("FAIL burst_count: got %0d exp 4", tx_log.size() - lb); else n_pass++;
      for (int i = 0; i < 4 && lb + i < tx_log.size(); i++) begin
         n_checks++; if (tx_log[lb+i] !== pat[i]) $display("FAIL burst_byte%0d: got %h exp %h", i, tx_log[lb+i], pat[i]); else n_pass++;
      end
      for (int i = 1; i < 4 && sb + i < start_t.size(); i++) begin
         n_checks++; if (start_t[sb+i] - start_t[sb+i-1] != busy_len + 4) $display("FAIL burst_spacing%0d: got %0d exp %0d", i, start_t[sb+i] - start_t[sb+i-1], busy_len + 4); else n_pass++;
      end
      n_checks++; if (sent_count !== CNT_W'(exp_sent)) $display("FAIL burst_sent_count: got %0d exp %0d", sent_count, exp_sent); else n_pass++;
      n_checks++; if (fifo_empty !== 1'b1) $display("FAIL burst_fifo_empty: got %b exp 1", fifo_empty); else n_pass++;
   endtask

   task automatic test_enable_drop();
      int p0 = pop_total, s0 = start_total, seen = 0;
      bit ok;
      busy_len = 8;
      fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
      enable = 1'b1;
      for (int i = 0; i < 40 && seen < 2; i++) begin
         @(negedge clk);
         if (start_total > s0 && tx_busy) seen++;
      end
      enable = 1'b0;
      drain(100, 1'b0, ok);
      repeat (10) @(negedge clk);
      exp_sent++;
      n_checks++; if (!ok || seen < 2) $display("FAIL drop_timeout: got busy exp idle"); else n_pass++;
      n_checks++; if (sent_count !== CNT_W'(exp_sent)) $display("FAIL drop_sent_count: got %0d exp %0d", sent_count, exp_sent); else n_pass++;
      n_checks++; if (fifo_q.size() != 2) $display("FAIL drop_fifo_left: got %0d exp 2", fifo_q.size()); else n_pass++;
      n_checks++; if (pop_total - p0 != 1) $display("FAIL drop_pops: got %0d exp 1", pop_total - p0); else n_pass++;
      n_checks++; if (tx_log[tx_log.size()-1] !== 8'h11) $display("FAIL drop_byte: got %h exp 11", tx_log[tx_log.size()-1]); else n_pass++;
   endtask

   task automatic test_flush();
      int p0, s0;
      bit ok;
      while (fifo_q.size() < 3) fifo_q.push_back(8'($urandom));
      @(negedge clk);
      p0 = pop_total; s0 = start_total;
      flush = 1'b1;
      enable = 1'b1;
      drain(60, 1'b1, ok);
      flush = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (!ok) $display("FAIL flush_timeout: got busy exp idle"); else n_pass++;
      n_checks++; if (pop_total - p0 != 3) $display("FAIL flush_pops: got %0d exp 3", pop_total - p0); else n_pass++;
      n_checks++; if (start_total != s0) $display("FAIL flush_no_start: got %0d exp %0d", start_total, s0); else n_pass++;
      n_checks++; if (underflow != 0) $display("FAIL flush_underflow: got %0d exp 0", underflow); else n_pass++;
      n_checks++; if (sent_count !== CNT_W'(exp_sent)) $display("FAIL flush_sent_count: got %0d exp %0d", sent_count, exp_sent); else n_pass++;
   endtask

   task automatic test_timeout();
      tx_mute = 1'b1;
      for (int round = 0; round < 2; round++) begin
         err_clear = (round == 1);
         fifo_q.push_back(8'($urandom));
         enable = 1'b1;
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_start) break;
         end
         enable = 1'b0;
         n_checks++; if (tx_start !== 1'b1) $display("FAIL timeout_start%0d: got %b exp 1", round, tx_start); else n_pass++;
         for (int k = 1; k <= BUSY_TIMEOUT + 1; k++) begin
            @(negedge clk);
            if (k == BUSY_TIMEOUT) begin
               n_checks++; if (err_timeout !== 1'b0 || active !== 1'b1) $display("FAIL timeout_early%0d: got err=%b act=%b exp err=0 act=1", round, err_timeout, active); else n_pass++;
            end
         end
         n_checks++; if (err_timeout !== 1'b1) $display("FAIL timeout_set%0d: got %b exp 1", round, err_timeout); else n_pass++;
         n_checks++; if (active !== 1'b0) $display("FAIL timeout_idle%0d: got %b exp 0", round, active); else n_pass++;
         if (round == 0) begin
            repeat (3) @(negedge clk);
            n_checks++; if (err_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b exp 1", err_timeout); else n_pass++;
            err_clear = 1'b1;
         end
         @(negedge clk);
         err_clear = 1'b0;
         n_checks++; if (err_timeout !== 1'b0) $display("FAIL timeout_clear%0d: got %b exp 0", round, err_timeout); else n_pass++;
      end
      tx_mute = 1'b0;
      n_checks++; if (sent_count !== CNT_W'(exp_sent)) $display("FAIL timeout_sent_count: got %0d exp %0d", sent_count, exp_sent); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int p0 = pop_total, s0 = start_total, seen = 0;
      bit ok;
      busy_len = 10;
      fifo_q.push_back(8'hC3); fifo_q.push_back(8'h3C);
      enable = 1'b1;
      for (int i = 0; i < 40 && seen < 2; i++) begin
         @(negedge clk);
         if (start_total > s0 && tx_busy) seen++;
      end
      n_rst = 1'b0;
      #1;
      exp_sent = 0;
      n_checks++; if (active !== 1'b0 || tx_start !== 1'b0 || fifo_renable !== 1'b0) $display("FAIL midreset_ctrl: got act=%b st=%b ren=%b exp 0", active, tx_start, fifo_renable); else n_pass++;
      n_checks++; if (tx_data !== 8'h00 || sent_count !== '0 || err_timeout !== 1'b0) $display("FAIL midreset_regs: got data=%h cnt=%0d err=%b exp 0", tx_data, sent_count, err_timeout); else n_pass++;
      @(negedge clk);
      n_rst = 1'b1;
      drain(100, 1'b1, ok);
      enable = 1'b0;
      exp_sent++;
      n_checks++; if (!ok || seen < 2) $display("FAIL midreset_timeout: got busy exp idle"); else n_pass++;
      n_checks++; if (tx_log[tx_log.size()-1] !== 8'h3C) $display("FAIL midreset_next_byte: got %h exp 3c", tx_log[tx_log.size()-1]); else n_pass++;
      n_checks++; if (sent_count !== CNT_W'(exp_sent)) $display("FAIL midreset_sent_count: got %0d exp %0d", sent_count, exp_sent); else n_pass++;
      n_checks++; if (pop_total - p0 != 2) $display("FAIL midreset_pops: got %0d exp 2", pop_total - p0); else n_pass++;
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         logic [7:0] exp_q[$];
         int n = $urandom_range(1, 5);
         int lb = tx_log.size();
         int sb = start_t.size();
         bit ok;
         busy_len = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            exp_q.push_back(8'($urandom));
            fifo_q.push_back(exp_q[i]);
         end
         enable = 1'b1;
         drain(n * 30 + 50, 1'b1, ok);
         enable = 1'b0;
         exp_sent += n;
         n_checks++; if (!ok || tx_log.size() - lb != n) $display("FAIL random%0d_count: got %0d exp %0d", r, tx_log.size() - lb, n); else n_pass++;
         for (int i = 0; i < n && lb + i < tx_log.size(); i++) begin
            n_checks++; if (tx_log[lb+i] !== exp_q[i]) $display("FAIL random%0d_byte%0d: got %h exp %h", r, i, tx_log[lb+i], exp_q[i]); else n_pass++;
         end
         for (int i = 1; i < n && sb + i < start_t.size(); i++) begin
            n_checks++; if (start_t[sb+i] - start_t[sb+i-1] != busy_len + 4) $display("FAIL random%0d_spacing: got %0d exp %0d", r, start_t[sb+i] - start_t[sb+i-1], busy_len + 4); else n_pass++;
         end
         n_checks++; if (sent_count !== CNT_W'(exp_sent)) $display("FAIL random%0d_sent_count: got %0d exp %0d", r, sent_count, exp_sent); else n_pass++;
      end
   endtask

   task automatic test_wrap();
      int n = (1 << CNT_W) - (exp_sent % (1 << CNT_W)) + 3;
      int lb = tx_log.size();
      bit ok;
      busy_len = 1;
      for (int i = 0; i < n; i++) fifo_q.push_back(8'($urandom));
      enable = 1'b1;
      drain(n * 8 + 100, 1'b1, ok);
      enable = 1'b0;
      exp_sent += n;
      n_checks++; if (!ok || tx_log.size() - lb != n) $display("FAIL wrap_count: got %0d exp %0d", tx_log.size() - lb, n); else n_pass++;
      n_checks++; if (sent_count !== CNT_W'(exp_sent)) $display("FAIL wrap_sent_count: got %0d exp %0d", sent_count, exp_sent % (1 << CNT_W)); else n_pass++;
      n_checks++; if (underflow != 0) $display("FAIL wrap_underflow: got %0d exp 0", underflow); else n_pass++;
   endtask

   initial begin
      n_rst     = 1'b1;
      enable    = 1'b0;
      flush     = 1'b0;
      err_clear = 1'b0;
      busy_len  = 10;
      tx_mute   = 1'b0;
      #1;
      test_reset();
      test_single_byte();
      test_burst();
      test_enable_drop();
      test_flush();
      test_timeout();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
